uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one UART transmitter, range 2..8.
REQ-002 Parameter TIMEOUT, default 15: maximum cycles in WAIT_BUSY before abort, range 1..255.
REQ-003 Port clk_50m  input  1  system clock, all logic on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port req_valid  input  N_REQ  bit i set: requester i has a byte pending.
REQ-006 Port req_data  input  8*N_REQ  requester i byte at [8i+7:8i].
REQ-007 Port req_ready  output  N_REQ  one-hot, one-cycle pulse: requester i byte accepted.
REQ-008 Port tx_busy  input  1  transmitter busy flag from UART.
REQ-009 Port uart_din  output  8  byte to UART transmitter din.
REQ-010 Port uart_wr_en  output  1  write strobe to UART transmitter wr_en.
REQ-011 Port grant_id  output  clog2(N_REQ)  index of the requester owning the current transfer.
REQ-012 Port active  output  1  high while state is not IDLE.
REQ-013 Port err_clr  input  1  clears timeout_err.
REQ-014 Port timeout_err  output  1  sticky: transmitter failed to assert tx_busy after a write.

Function
REQ-015 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE: when tx_busy=0 and req_valid!=0, select winner w, load uart_din<=req_data[w], grant_id<=w, req_ready[w]<=1, uart_wr_en<=1, go ISSUE; otherwise remain, outputs idle.
REQ-018 IDLE with tx_busy=1 SHALL NOT grant, regardless of req_valid.
REQ-019 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod N_REQ, first set req_valid bit wins; last_grant resets to N_REQ-1 so requester 0 has first priority.
REQ-020 last_grant SHALL update to w on the grant edge.
REQ-021 ISSUE: one cycle; req_ready and uart_wr_en high exactly this cycle; next state WAIT_BUSY, clear timeout counter.
REQ-022 WAIT_BUSY: uart_wr_en=0; if tx_busy=1 go WAIT_DONE; else increment counter; when counter reaches TIMEOUT, set timeout_err, go IDLE (byte is lost, not retried).
REQ-023 WAIT_DONE: remain while tx_busy=1; on tx_busy=0 go IDLE.
REQ-024 Grant latency: req_valid sampled high in IDLE gives req_ready pulse on the next cycle; uart_din stable from ISSUE until the next grant.
REQ-025 Requester SHALL hold req_valid and req_data until req_ready; a request dropped before grant is simply not served.
REQ-026 A requester keeping req_valid high after req_ready presents its next byte; it is re-eligible only after all other valid requesters have been served once.
REQ-027 timeout_err: set and err_clr in same cycle -> set wins; otherwise err_clr=1 clears it.
REQ-028 Timeout counter width SHALL be clog2(TIMEOUT+1) and SHALL NOT wrap.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, req_ready=0, uart_wr_en=0, uart_din=0, grant_id=0, active=0, timeout_err=0, counter=0, last_grant=N_REQ-1, including mid-transfer; no pending grant survives reset.
REQ-030 After rst_n rises, first grant SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-031 Single request: req_valid=0001, data[7:0]=0xA5, tx_busy rises 1 cycle after wr_en and stays 10 cycles -> one wr_en pulse, uart_din=0xA5, req_ready=0001 once, active falls 1 cycle after tx_busy falls.
REQ-032 All four valid continuously -> grant order 0,1,2,3,0 with grant_id matching, exactly one req_ready bit per transfer.
REQ-033 tx_busy never rises after ISSUE, TIMEOUT=15 -> timeout_err=1 after 15 WAIT_BUSY cycles, return to IDLE, next request served normally; err_clr pulse -> timeout_err=0.
REQ-034 tx_busy=1 held in IDLE with req_valid=0010 -> no req_ready/wr_en until tx_busy=0, then grant to requester 1 next cycle.
REQ-035 rst_n asserted during WAIT_DONE -> all outputs at reset values same cycle; after release with req_valid=1000|0001, requester 0 granted first.
REQ-036 err_clr and timeout in same cycle -> timeout_err=1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets N_REQ byte sources share one UART transmitter.
// A grant loads the winner's byte, pulses req_ready/uart_wr_en for one cycle,
// then waits for the transmitter to show busy and go idle again. A watchdog on
// the busy handshake drops the byte and raises a sticky error if it never comes.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                       clk_50m,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [8*N_REQ-1:0]         req_data,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       tx_busy,
    output logic [7:0]                 uart_din,
    output logic                       uart_wr_en,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       active,
    input  logic                       err_clr,
    output logic                       timeout_err
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t            state_q;
    logic [N_REQ-1:0]  ready_q;
    logic [7:0]        din_q;
    logic              wr_en_q;
    logic [GW-1:0]     grant_q;
    logic [GW-1:0]     last_q;
    logic              active_q;
    logic              err_q;
    logic [CW-1:0]     cnt_q;

    logic [GW-1:0]     win_d;
    logic [7:0]        din_d;
    logic [N_REQ-1:0]  ready_d;
    logic              grant_d;
    logic [CW-1:0]     cnt_d;
    logic              timeout_d;

    // First set bit strictly above the last winner, else first set bit from 0.
    function automatic logic [GW-1:0] rr_pick(input logic [N_REQ-1:0] vld,
                                              input logic [GW-1:0]    last);
        logic [GW-1:0] pick;
        logic          found;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && vld[i] && (i > int'(last))) begin
                pick  = GW'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && vld[i]) begin
                pick  = GW'(i);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Winner selection, its byte and one-hot ready, and watchdog next values.
    always_comb begin
        win_d   = rr_pick(req_valid, last_q);
        din_d   = '0;
        ready_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_d == GW'(i)) begin
                din_d      = req_data[8*i +: 8];
                ready_d[i] = 1'b1;
            end
        end
        grant_d   = (state_q == IDLE) && !tx_busy && (|req_valid);
        cnt_d     = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
        timeout_d = (state_q == WAIT_BUSY) && !tx_busy && (cnt_d == CW'(TIMEOUT));
    end

    // Transfer FSM with all handshake outputs registered alongside the state.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ready_q  <= '0;
            din_q    <= '0;
            wr_en_q  <= 1'b0;
            grant_q  <= '0;
            last_q   <= GW'(N_REQ - 1);
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            ready_q <= '0;
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        din_q    <= din_d;
                        grant_q  <= win_d;
                        last_q   <= win_d;
                        ready_q  <= ready_d;
                        wr_en_q  <= 1'b1;
                        active_q <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                        if (timeout_d) begin
                            state_q  <= IDLE;
                            active_q <= 1'b0;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_q  <= IDLE;
                        active_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    // Sticky watchdog flag; a new timeout outranks a simultaneous clear.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (timeout_d) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign req_ready   = ready_q;
    assign uart_din    = din_q;
    assign uart_wr_en  = wr_en_q;
    assign grant_id    = grant_q;
    assign active      = active_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues feed the DUT, a round-robin
// model predicts the (requester, byte) order of writes, a monitor scores each
// write, and a UART responder emulates busy timing or a missing busy.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 15;
    localparam int GW = 2;

    logic           clk_50m = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           tx_busy;
    logic [7:0]     uart_din;
    logic           uart_wr_en;
    logic [GW-1:0]  grant_id;
    logic           active;
    logic           err_clr;
    logic           timeout_err;

    logic man_mode, man_busy, auto_busy;
    logic rand_mode, force_drop, resp_busy;

    assign tx_busy = man_mode ? man_busy : auto_busy;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_busy    (tx_busy),
        .uart_din   (uart_din),
        .uart_wr_en (uart_wr_en),
        .grant_id   (grant_id),
        .active     (active),
        .err_clr    (err_clr),
        .timeout_err(timeout_err)
    );

    always #10 clk_50m = ~clk_50m;

    typedef struct packed {
        logic [GW-1:0] id;
        logic [7:0]    data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rq[N][$];
    int         model_last = N - 1;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic push_req(input int i, input logic [7:0] b);
        rq[i].push_back(b);
    endtask

    // Round-robin over the pending bytes: next owner is the first requester
    // after the previous owner (cyclically) that still has bytes.
    task automatic plan();
        logic [7:0] cp[N][$];
        int total;
        total = 0;
        for (int i = 0; i < N; i++) begin
            cp[i] = rq[i];
            total += cp[i].size();
        end
        repeat (total) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (model_last + k) % N;
                if (cp[c].size() > 0) begin
                    exp_q.push_back('{id: GW'(c), data: cp[c].pop_front()});
                    model_last = c;
                    break;
                end
            end
        end
    endtask

    function automatic bit rq_empty();
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk_50m);
            k++;
        end while ((exp_q.size() != 0 || !rq_empty() || active || resp_busy) && k < 3000);
        if (k >= 3000) begin
            n_chk++;
            n_fail++;
            $display("FAIL idle_%s: got pending=%0d expected pending=0", tag, exp_q.size());
        end
    endtask

    // Requesters: hold the head byte valid until its ready pulse.
    initial begin
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(negedge clk_50m);
            for (int i = 0; i < N; i++) begin
                if (rst_n && req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                req_valid[i]       = (rq[i].size() > 0);
                req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
            end
        end
    end

    // Monitor: score each write and check outputs hold between grants.
    initial begin
        exp_t       e;
        logic [7:0] last_din;
        logic [GW-1:0] last_gid;
        logic       prev_wr;
        last_din = '0;
        last_gid = '0;
        prev_wr  = 1'b0;
        forever begin
            @(negedge clk_50m);
            if (!rst_n) begin
                last_din = '0;
                last_gid = '0;
                prev_wr  = 1'b0;
            end else begin
                if (uart_wr_en) begin
                    check("wr_en_single_cycle", 32'(prev_wr), 0);
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_grant: got grant_id=%0d expected no grant", grant_id);
                    end else begin
                        e = exp_q.pop_front();
                        check("grant_id", 32'(grant_id), 32'(e.id));
                        check("uart_din", 32'(uart_din), 32'(e.data));
                        check("req_ready_onehot", 32'(req_ready), 32'(1) << e.id);
                    end
                    last_din = uart_din;
                    last_gid = grant_id;
                end else begin
                    check("req_ready_idle", 32'(req_ready), 0);
                    check("din_stable", 32'(uart_din), 32'(last_din));
                    check("grant_stable", 32'(grant_id), 32'(last_gid));
                end
                prev_wr = uart_wr_en;
            end
        end
    end

    // UART responder: busy after d cycles for L cycles, or never (timeout).
    initial begin
        int d, len;
        bit drop, same;
        auto_busy = 1'b0;
        err_clr   = 1'b0;
        resp_busy = 1'b0;
        @(negedge clk_50m);
        forever begin
            while (!(rst_n && uart_wr_en && !man_mode)) @(negedge clk_50m);
            resp_busy = 1'b1;
            drop = force_drop || (rand_mode && $urandom_range(0, 5) == 0);
            force_drop = 1'b0;
            if (drop) begin
                same = 1'($urandom_range(0, 1));
                for (int k = 1; k <= TO; k++) begin
                    @(negedge clk_50m);
                    if (k == TO) begin
                        check("err_before_timeout", 32'(timeout_err), 0);
                        check("active_before_timeout", 32'(active), 1);
                        if (same) err_clr = 1'b1;
                    end
                end
                @(negedge clk_50m);
                check("timeout_err_set", 32'(timeout_err), 1);
                check("active_after_timeout", 32'(active), 0);
                err_clr = 1'b1;
                @(negedge clk_50m);
                err_clr = 1'b0;
                check("timeout_err_cleared", 32'(timeout_err), 0);
            end else begin
                d   = rand_mode ? int'($urandom_range(1, 3)) : 1;
                len = rand_mode ? int'($urandom_range(1, 6)) : 10;
                repeat (d) @(negedge clk_50m);
                auto_busy = 1'b1;
                repeat (len) @(negedge clk_50m);
                auto_busy = 1'b0;
                check("active_during_busy", 32'(active), 1);
                @(negedge clk_50m);
                check("active_after_busy", 32'(active), 0);
            end
            resp_busy = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] mask;
        bit seen;
        rst_n      = 1'b0;
        man_mode   = 1'b0;
        man_busy   = 1'b0;
        rand_mode  = 1'b0;
        force_drop = 1'b0;
        repeat (3) @(negedge clk_50m);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_wr_en", 32'(uart_wr_en), 0);
        check("rst_din", 32'(uart_din), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_active", 32'(active), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        rst_n = 1'b1;

        // single byte, busy one cycle after the write for ten cycles
        push_req(0, 8'hA5);
        plan();
        wait_idle("single");

        // all four requesters with two bytes each
        for (int i = 0; i < N; i++) begin
            push_req(i, 8'($urandom));
            push_req(i, 8'($urandom));
        end
        plan();
        wait_idle("all_four");

        // transmitter never shows busy, then a normal transfer
        force_drop = 1'b1;
        push_req(2, 8'($urandom));
        plan();
        wait_idle("timeout");
        push_req(2, 8'($urandom));
        plan();
        wait_idle("after_timeout");

        // busy held in IDLE blocks the grant until it drops
        man_mode = 1'b1;
        man_busy = 1'b1;
        push_req(1, 8'($urandom));
        plan();
        repeat (6) begin
            @(negedge clk_50m);
            check("no_wr_while_busy", 32'(uart_wr_en), 0);
            check("no_ready_while_busy", 32'(req_ready), 0);
        end
        man_busy = 1'b0;
        @(negedge clk_50m);
        check("grant_after_busy_drop", 32'(uart_wr_en), 1);
        @(negedge clk_50m);
        man_busy = 1'b1;
        repeat (3) @(negedge clk_50m);
        man_busy = 1'b0;
        @(negedge clk_50m);
        check("active_after_manual", 32'(active), 0);
        man_mode = 1'b0;

        // randomized sessions
        rand_mode = 1'b1;
        repeat (25) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    repeat ($urandom_range(1, 3)) push_req(i, 8'($urandom));
                end
            end
            plan();
            wait_idle("random");
        end
        rand_mode = 1'b0;

        // reset while the transmitter is busy
        man_mode = 1'b1;
        man_busy = 1'b0;
        push_req(2, 8'($urandom));
        plan();
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk_50m);
            seen = uart_wr_en;
        end
        check("reset_test_grant", 32'(seen), 1);
        @(negedge clk_50m);
        man_busy = 1'b1;
        repeat (3) @(negedge clk_50m);
        check("reset_test_active", 32'(active), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", 32'(req_ready), 0);
        check("midrst_wr_en", 32'(uart_wr_en), 0);
        check("midrst_din", 32'(uart_din), 0);
        check("midrst_grant_id", 32'(grant_id), 0);
        check("midrst_active", 32'(active), 0);
        check("midrst_timeout_err", 32'(timeout_err), 0);
        man_busy   = 1'b0;
        man_mode   = 1'b0;
        model_last = N - 1;
        push_req(3, 8'($urandom));
        push_req(0, 8'($urandom));
        plan();
        repeat (2) @(negedge clk_50m);
        rst_n = 1'b1;
        wait_idle("after_reset");

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
